// File: rtl/uart_pkg.sv
// Definitions shared by the UART transmit and receive sides.
// Covers frame state encodings, parity mode codes and parameter legality limits.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    localparam int DATA_W_MIN       = 5;
    localparam int DATA_W_MAX       = 9;
    localparam int STOP_BITS_MIN    = 1;
    localparam int STOP_BITS_MAX    = 2;
    localparam int CLKS_PER_BIT_MIN = 2;

    // Returns 1 when a parity mode code names one of the supported modes.
    function automatic bit parity_mode_ok(input int mode);
        return (mode == PARITY_NONE) || (mode == PARITY_EVEN) || (mode == PARITY_ODD);
    endfunction

endpackage

// File: rtl/uart_tx_engine_if.sv
// Word handshake between the byte source and the UART transmitter.
// A word moves on a rising edge where tx_valid and tx_ready are both high; tx_data must be stable while tx_valid is high.
interface uart_tx_engine_if #(
    parameter int DATA_W = 8
);

    logic              tx_valid;
    logic [DATA_W-1:0] tx_data;
    logic              tx_ready;

    modport master (
        output tx_valid,
        output tx_data,
        input  tx_ready
    );

    modport slave (
        input  tx_valid,
        input  tx_data,
        output tx_ready
    );

endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period divider: bit_tick is high on the last cycle of every CLKS_PER_BIT-cycle period.
// restart holds the count at zero, so the first period after restart drops is a full period.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clock,
    input  logic reset,
    input  logic restart,
    output logic bit_tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] TERMINAL = CW'(CLKS_PER_BIT - 1);

    if (CLKS_PER_BIT < CLKS_PER_BIT_MIN) begin : g_bad_clks_per_bit
        $error("uart_baud_gen: CLKS_PER_BIT=%0d is below %0d", CLKS_PER_BIT, CLKS_PER_BIT_MIN);
    end

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign bit_tick = (cnt_q == TERMINAL);

    always_comb begin
        cnt_d = cnt_q;
        if (restart || bit_tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmitter: start bit, DATA_W data bits LSB first, optional parity, STOP_BITS stop bits.
// Accepts one word per frame through a valid/ready handshake and pulses tx_done after the last stop bit.
module uart_tx_engine
    import uart_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int PARITY       = 1,
    parameter int STOP_BITS    = 1,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic             clock,
    input  logic             reset,
    uart_tx_engine_if.slave  tx_if,
    output logic             tx_serial,
    output logic             busy,
    output logic             tx_done,
    output uart_state_e      dbg_state
);

    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_W - 1);
    localparam logic          LAST_STOP = 1'(STOP_BITS - 1);
    localparam bit            HAS_PARITY = (PARITY != PARITY_NONE);

    if (DATA_W < DATA_W_MIN || DATA_W > DATA_W_MAX) begin : g_bad_data_w
        $error("uart_tx_engine: DATA_W=%0d outside %0d..%0d", DATA_W, DATA_W_MIN, DATA_W_MAX);
    end
    if (!parity_mode_ok(PARITY)) begin : g_bad_parity
        $error("uart_tx_engine: PARITY=%0d is not 0, 1 or 2", PARITY);
    end
    if (STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX) begin : g_bad_stop_bits
        $error("uart_tx_engine: STOP_BITS=%0d outside %0d..%0d", STOP_BITS, STOP_BITS_MIN, STOP_BITS_MAX);
    end

    uart_state_e       state_q,     state_d;
    logic [DATA_W-1:0] shreg_q,     shreg_d;
    logic [BW-1:0]     bit_cnt_q,   bit_cnt_d;
    logic              stop_cnt_q,  stop_cnt_d;
    logic              parity_q,    parity_d;
    logic              tx_serial_q, tx_serial_d;
    logic              busy_q,      busy_d;
    logic              tx_done_q,   tx_done_d;

    logic bit_tick;
    logic accept;

    assign tx_if.tx_ready = (state_q == ST_IDLE);
    assign accept         = tx_if.tx_valid && tx_if.tx_ready;

    assign tx_serial = tx_serial_q;
    assign busy      = busy_q;
    assign tx_done   = tx_done_q;
    assign dbg_state = state_q;

    // Holding the divider at zero while idle makes every frame start on a fresh bit period.
    uart_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_gen (
        .clock    (clock),
        .reset    (reset),
        .restart  (state_q == ST_IDLE),
        .bit_tick (bit_tick)
    );

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        bit_cnt_d   = bit_cnt_q;
        stop_cnt_d  = stop_cnt_q;
        parity_d    = parity_q;
        tx_serial_d = tx_serial_q;
        tx_done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                tx_serial_d = 1'b1;
                if (accept) begin
                    state_d     = ST_START;
                    shreg_d     = tx_if.tx_data;
                    parity_d    = (PARITY == PARITY_ODD) ? ~^tx_if.tx_data : ^tx_if.tx_data;
                    bit_cnt_d   = '0;
                    stop_cnt_d  = 1'b0;
                    tx_serial_d = 1'b0;
                end
            end

            ST_START: begin
                if (bit_tick) begin
                    state_d     = ST_DATA;
                    tx_serial_d = shreg_q[0];
                end
            end

            ST_DATA: begin
                if (bit_tick) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        if (HAS_PARITY) begin
                            state_d     = ST_PARITY;
                            tx_serial_d = parity_q;
                        end else begin
                            state_d     = ST_STOP;
                            tx_serial_d = 1'b1;
                        end
                    end else begin
                        bit_cnt_d   = bit_cnt_q + 1'b1;
                        shreg_d     = shreg_q >> 1;
                        tx_serial_d = shreg_d[0];
                    end
                end
            end

            ST_PARITY: begin
                if (bit_tick) begin
                    state_d     = ST_STOP;
                    tx_serial_d = 1'b1;
                end
            end

            ST_STOP: begin
                tx_serial_d = 1'b1;
                if (bit_tick) begin
                    if (stop_cnt_q == LAST_STOP) begin
                        state_d   = ST_IDLE;
                        tx_done_d = 1'b1;
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d     = ST_IDLE;
                tx_serial_d = 1'b1;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            stop_cnt_q  <= 1'b0;
            parity_q    <= 1'b0;
            tx_serial_q <= 1'b1;
            busy_q      <= 1'b0;
            tx_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            stop_cnt_q  <= stop_cnt_d;
            parity_q    <= parity_d;
            tx_serial_q <= tx_serial_d;
            busy_q      <= busy_d;
            tx_done_q   <= tx_done_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed bench for uart_tx_engine: three instances (8-bit even, 8-bit odd, 7-bit no parity with 2 stops).
// Every serial bit period is compared against hand-derived frame images.
module tb_uart_tx_engine;
  import uart_pkg::*;

  localparam int CPB = 4;

  logic clk;
  logic reset;

  int vectors;
  int miscompares;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  uart_tx_engine_if #(.DATA_W(8)) a_if ();
  uart_tx_engine_if #(.DATA_W(8)) b_if ();
  uart_tx_engine_if #(.DATA_W(7)) c_if ();

  logic a_ser, a_busy, a_done;
  logic b_ser, b_busy, b_done;
  logic c_ser, c_busy, c_done;
  uart_state_e a_state, b_state, c_state;

  uart_tx_engine #(.DATA_W(8), .PARITY(1), .STOP_BITS(1), .CLKS_PER_BIT(CPB)) u_even (
    .clock (clk), .reset (reset), .tx_if (a_if),
    .tx_serial (a_ser), .busy (a_busy), .tx_done (a_done), .dbg_state (a_state)
  );

  uart_tx_engine #(.DATA_W(8), .PARITY(2), .STOP_BITS(1), .CLKS_PER_BIT(CPB)) u_odd (
    .clock (clk), .reset (reset), .tx_if (b_if),
    .tx_serial (b_ser), .busy (b_busy), .tx_done (b_done), .dbg_state (b_state)
  );

  uart_tx_engine #(.DATA_W(7), .PARITY(0), .STOP_BITS(2), .CLKS_PER_BIT(CPB)) u_nopar (
    .clock (clk), .reset (reset), .tx_if (c_if),
    .tx_serial (c_ser), .busy (c_busy), .tx_done (c_done), .dbg_state (c_state)
  );

  function automatic logic ser_of(input int w);
    case (w)
      0:       return a_ser;
      1:       return b_ser;
      default: return c_ser;
    endcase
  endfunction

  function automatic logic busy_of(input int w);
    case (w)
      0:       return a_busy;
      1:       return b_busy;
      default: return c_busy;
    endcase
  endfunction

  function automatic logic done_of(input int w);
    case (w)
      0:       return a_done;
      1:       return b_done;
      default: return c_done;
    endcase
  endfunction

  function automatic logic ready_of(input int w);
    case (w)
      0:       return a_if.tx_ready;
      1:       return b_if.tx_ready;
      default: return c_if.tx_ready;
    endcase
  endfunction

  // Frame image, bit 0 first on the line: start, data LSB first, optional parity, stop bits.
  function automatic logic [15:0] mk_frame(input logic [8:0] d, input int dw,
                                           input bit has_par, input logic par, input int stops);
    logic [15:0] f;
    int idx;
    f = '0;
    f[0] = 1'b0;
    for (int i = 0; i < dw; i++) f[1 + i] = d[i];
    idx = 1 + dw;
    if (has_par) begin
      f[idx] = par;
      idx++;
    end
    for (int s = 0; s < stops; s++) begin
      f[idx] = 1'b1;
      idx++;
    end
    return f;
  endfunction

  task automatic chk(input logic observed, input logic expected, input string tag);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, observed, expected);
    end
  endtask

  // Called just after a rising edge; presents a word and returns just after the accept edge.
  task automatic send(input int w, input logic [8:0] d, input bit hold);
    case (w)
      0: begin a_if.tx_valid = 1'b1; a_if.tx_data = d[7:0]; end
      1: begin b_if.tx_valid = 1'b1; b_if.tx_data = d[7:0]; end
      default: begin c_if.tx_valid = 1'b1; c_if.tx_data = d[6:0]; end
    endcase
    @(posedge clk);
    #1;
    if (!hold) begin
      a_if.tx_valid = 1'b0;
      b_if.tx_valid = 1'b0;
      c_if.tx_valid = 1'b0;
    end
  endtask

  // Entered in the first cycle after accept; checks every cycle of the frame and the first idle cycle.
  task automatic check_frame(input int w, input logic [15:0] bits, input int nbits,
                             input bit toggle, input string tag);
    for (int i = 0; i < nbits * CPB; i++) begin
      @(negedge clk);
      chk(ser_of(w), bits[i / CPB], $sformatf("%s_bit%0d_cyc%0d", tag, i / CPB, i));
      chk(busy_of(w), 1'b1, $sformatf("%s_busy_cyc%0d", tag, i));
      chk(done_of(w), 1'b0, $sformatf("%s_done_early_cyc%0d", tag, i));
      @(posedge clk);
      #1;
      if (toggle) a_if.tx_data = 8'($urandom_range(0, 255));
    end
    @(negedge clk);
    chk(done_of(w),  1'b1, {tag, "_done_pulse"});
    chk(ser_of(w),   1'b1, {tag, "_gap_high"});
    chk(ready_of(w), 1'b1, {tag, "_ready_idle"});
    chk(busy_of(w),  1'b0, {tag, "_busy_idle"});
    @(posedge clk);
    #1;
  endtask

  task automatic idle_check(input int w, input string tag);
    @(negedge clk);
    chk(done_of(w),  1'b0, {tag, "_done_single"});
    chk(ser_of(w),   1'b1, {tag, "_idle_line"});
    chk(ready_of(w), 1'b1, {tag, "_idle_ready"});
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset = 1'b1;
    a_if.tx_valid = 1'b0; a_if.tx_data = '0;
    b_if.tx_valid = 1'b0; b_if.tx_data = '0;
    c_if.tx_valid = 1'b0; c_if.tx_data = '0;

    // Reset state on all three instances.
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int w = 0; w < 3; w++) begin
      chk(ser_of(w),   1'b1, $sformatf("rst_serial_%0d", w));
      chk(ready_of(w), 1'b1, $sformatf("rst_ready_%0d", w));
      chk(busy_of(w),  1'b0, $sformatf("rst_busy_%0d", w));
      chk(done_of(w),  1'b0, $sformatf("rst_done_%0d", w));
    end
    chk(logic'(a_state == ST_IDLE), 1'b1, "rst_state_idle");
    @(posedge clk);
    #1;
    reset = 1'b0;

    // 8'hA5 even parity: 0,1,0,1,0,0,1,0,1,0(par),1(stop).
    send(0, 9'h0A5, 1'b0);
    check_frame(0, 16'b0000_0101_0100_1010, 11, 1'b0, "even_a5");
    idle_check(0, "even_a5");

    // Odd parity: 8'h01 -> parity 0, 8'h03 -> parity 1.
    send(1, 9'h001, 1'b0);
    check_frame(1, mk_frame(9'h001, 8, 1'b1, 1'b0, 1), 11, 1'b0, "odd_01");
    idle_check(1, "odd_01");
    send(1, 9'h003, 1'b0);
    check_frame(1, mk_frame(9'h003, 8, 1'b1, 1'b1, 1), 11, 1'b0, "odd_03");
    idle_check(1, "odd_03");

    // 7-bit, no parity, two stop bits: 10 bit periods = 40 clocks.
    send(2, 9'h07F, 1'b0);
    check_frame(2, 16'b0000_0011_1111_1110, 10, 1'b0, "nopar_7f");
    idle_check(2, "nopar_7f");

    // Back-to-back with tx_valid held: 8'h55 then 8'hAA, one idle clock between frames.
    send(0, 9'h055, 1'b1);
    a_if.tx_data = 8'hAA;
    check_frame(0, mk_frame(9'h055, 8, 1'b1, 1'b0, 1), 11, 1'b0, "b2b_55");
    a_if.tx_valid = 1'b0;
    check_frame(0, mk_frame(9'h0AA, 8, 1'b1, 1'b0, 1), 11, 1'b0, "b2b_aa");
    idle_check(0, "b2b_aa");

    // Reset pulse during data bit 3 (cycles 16..19 after accept).
    send(0, 9'h0A5, 1'b0);
    repeat (17) @(posedge clk);
    @(negedge clk);
    chk(a_ser, 1'b0, "abort_bit3_before_reset");
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk(a_ser,         1'b1, "abort_serial");
    chk(a_if.tx_ready, 1'b1, "abort_ready");
    chk(a_busy,        1'b0, "abort_busy");
    chk(a_done,        1'b0, "abort_done");
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      chk(a_done, 1'b0, $sformatf("abort_no_done_%0d", i));
      chk(a_ser,  1'b1, $sformatf("abort_line_high_%0d", i));
    end
    @(posedge clk);
    #1;
    send(0, 9'h0C3, 1'b0);
    check_frame(0, mk_frame(9'h0C3, 8, 1'b1, 1'b0, 1), 11, 1'b0, "post_abort_c3");
    idle_check(0, "post_abort_c3");

    // tx_data scrambled every cycle while busy: the word latched at accept (8'h3C) must go out.
    send(0, 9'h03C, 1'b0);
    check_frame(0, mk_frame(9'h03C, 8, 1'b1, 1'b0, 1), 11, 1'b1, "latched_3c");
    idle_check(0, "latched_3c");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
